// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache and its main-memory responder:
// memory geometry, cache line field positions and the responder state encoding.
package cache_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;

  // Cache line layout: {valid, lru, dirty, tag[2:0], data[2:0]}
  localparam int LINE_VALID    = 8;
  localparam int LINE_LRU      = 7;
  localparam int LINE_DIRTY    = 6;
  localparam int LINE_TAG_MSB  = 5;
  localparam int LINE_TAG_LSB  = 3;
  localparam int LINE_DATA_MSB = 2;
  localparam int LINE_DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/main_mem_array.sv
// Main-memory word array: asynchronous reset to the identity pattern (word a holds a),
// one synchronous write port and one combinational read port.
module main_mem_array #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Identity contents reproduce the legacy "data = tag" fill right after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder for the cache: serves line fills and dirty write-backs one at a time,
// answering each accepted request after a fixed wait over a valid/ready response channel.
module main_mem_responder #(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int DATA_W  = cache_pkg::DATA_W,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_write,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef cache_pkg::resp_state_t state_t;

  localparam logic [3:0]       WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state_reg, state_next;
  logic [3:0]        wait_reg, wait_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              accept, access, done;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= cache_pkg::IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    accept     = 1'b0;
    access     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      cache_pkg::IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            access     = 1'b1;
            state_next = cache_pkg::RESP;
          end else begin
            wait_next  = WAIT_INIT;
            state_next = cache_pkg::WAIT;
          end
        end
      end
      cache_pkg::WAIT: begin
        if (wait_reg == 4'd0) begin
          access     = 1'b1;
          state_next = cache_pkg::RESP;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      cache_pkg::RESP: begin
        if (resp_ready) begin
          done       = 1'b1;
          state_next = cache_pkg::IDLE;
        end
      end
      default: state_next = cache_pkg::IDLE;
    endcase
  end

  // A zero-latency access happens on the accept edge, so it must use the live request
  assign acc_addr  = accept ? req_addr  : addr_reg;
  assign acc_write = accept ? req_write : write_reg;
  assign acc_wdata = accept ? req_wdata : wdata_reg;

  main_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .we   (access && acc_write),
    .waddr(acc_addr),
    .wdata(acc_wdata),
    .raddr(acc_addr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_reg   <= 4'd0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      resp_rdata <= '0;
      resp_write <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      wait_reg <= wait_next;
      if (accept) begin
        addr_reg  <= req_addr;
        write_reg <= req_write;
        wdata_reg <= req_wdata;
      end
      if (access) begin
        resp_rdata <= acc_write ? acc_wdata : mem_rdata;
        resp_write <= acc_write;
      end
      if (done) begin
        if (resp_write) begin
          if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
        end else if (rd_cnt != CNT_MAX) begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign req_ready  = (state_reg == cache_pkg::IDLE);
  assign busy       = (state_reg != cache_pkg::IDLE);
  assign resp_valid = (state_reg == cache_pkg::RESP);

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomised and directed bench for main_mem_responder, checked every cycle against a
// transaction-level reference model (memory array plus accept time and due time per request).
module tb_main_mem_responder;

  localparam int AW    = 5;
  localparam int DW    = 3;
  localparam int LAT   = 2;
  localparam int CW    = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int CMAX  = 2 ** CW - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_write, busy;
  logic [DW-1:0] resp_rdata;
  logic [CW-1:0] rd_cnt, wr_cnt;

  // Zero-latency build
  logic          req_valid_z = 1'b0, req_write_z = 1'b0, resp_ready_z = 1'b0;
  logic [AW-1:0] req_addr_z  = '0;
  logic [DW-1:0] req_wdata_z = '0;
  logic          req_ready_z, resp_valid_z, resp_write_z, busy_z;
  logic [DW-1:0] resp_rdata_z;
  logic [CW-1:0] rd_cnt_z, wr_cnt_z;

  main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(0), .CNT_W(CW)) dut_z (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_rdata(resp_rdata_z),
    .resp_write(resp_write_z), .busy(busy_z), .rd_cnt(rd_cnt_z), .wr_cnt(wr_cnt_z)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: one request in flight, visible from accept_cycle + LAT until consumed
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend, m_shown, m_rwrite, p_write;
  logic [DW-1:0] m_rdata, p_data;
  int            m_cyc, m_due, m_rd_total, m_wr_total;

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(i);
      m_pend = 0; m_shown = 0; m_rwrite = 0; m_rdata = '0;
      m_cyc = 0; m_rd_total = 0; m_wr_total = 0;
    end else begin
      if (m_shown) begin
        if (resp_ready) begin
          m_shown = 0;
          if (m_rwrite) m_wr_total++;
          else          m_rd_total++;
        end
      end else if (m_pend) begin
        if (m_cyc == m_due) begin
          m_pend = 0; m_shown = 1; m_rdata = p_data; m_rwrite = p_write;
        end
      end else if (req_valid) begin
        p_write = req_write;
        if (req_write) begin
          m_mem[req_addr] = req_wdata;
          p_data = req_wdata;
        end else begin
          p_data = m_mem[req_addr];
        end
        m_due = m_cyc + LAT;
        if (LAT == 0) begin
          m_shown = 1; m_rdata = p_data; m_rwrite = p_write;
        end else begin
          m_pend = 1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clock) begin
    check("req_ready",  int'(req_ready),  int'(!(m_pend || m_shown)));
    check("busy",       int'(busy),       int'(m_pend || m_shown));
    check("resp_valid", int'(resp_valid), int'(m_shown));
    check("resp_rdata", int'(resp_rdata), int'(m_rdata));
    check("resp_write", int'(resp_write), int'(m_rwrite));
    check("rd_cnt",     int'(rd_cnt),     sat(m_rd_total));
    check("wr_cnt",     int'(wr_cnt),     sat(m_wr_total));
  end

  task automatic do_reset();
    @(negedge clock); #2 reset = 1'b1;
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
  endtask

  // Called just after a negedge with the responder idle; returns edges until resp_valid
  task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rdata, output bit rwrite, output int edges);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b1;
    edges = 0;
    do begin
      @(negedge clock);
      edges++;
      req_valid = 1'b0;
    end while (!resp_valid && edges < 20);
    rdata  = resp_rdata;
    rwrite = resp_write;
    @(negedge clock);
    $display("txn %s addr=%0d wdata=%0d -> rdata=%0d write=%0d edges=%0d",
             w ? "WR" : "RD", a, d, rdata, rwrite, edges);
  endtask

  logic [DW-1:0] rd;
  bit            rw;
  int            lat, k;

  initial begin
    #1 reset = 1'b1;
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
    check("t1_reset_ready", int'(req_ready), 1);
    check("t1_reset_rdata", int'(resp_rdata), 0);

    // 1: fill read after reset returns the identity pattern
    do_txn(1'b0, 5'd13, 3'd0, rd, rw, lat);
    check("t1_latency", lat, 3);
    check("t1_rdata", int'(rd), 5);
    check("t1_rd_cnt", int'(rd_cnt), 1);

    // 2: write-back echo, then read-after-write
    do_reset();
    do_txn(1'b1, 5'd13, 3'd2, rd, rw, lat);
    check("t2_wr_echo", int'(rd), 2);
    check("t2_wr_flag", int'(rw), 1);
    do_txn(1'b0, 5'd13, 3'd0, rd, rw, lat);
    check("t2_raw_rdata", int'(rd), 2);
    check("t2_wr_cnt", int'(wr_cnt), 1);
    check("t2_rd_cnt", int'(rd_cnt), 1);

    // 3: response held under back-pressure; requests during RESP are ignored
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd20; resp_ready = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; req_valid = 1'b0; end while (!resp_valid && k < 20);
    for (int i = 0; i < 4; i++) begin
      req_valid = (i % 2 == 0); req_addr = 5'd7;
      @(negedge clock);
      check("t3_hold_valid", int'(resp_valid), 1);
      check("t3_hold_rdata", int'(resp_rdata), 4);
      check("t3_hold_ready", int'(req_ready), 0);
    end
    req_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clock);
    check("t3_idle_gap", int'(req_ready), 1);
    @(negedge clock);
    req_valid = 1'b0;
    check("t3_accept7", int'(busy), 1);
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clock); k++; end
    check("t3_rdata7", int'(resp_rdata), 7);
    @(negedge clock);

    // 4: reset during the wait of a write loses the write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd4; req_wdata = 3'd1; resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t4_rst_valid", int'(resp_valid), 0);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_rd_cnt", int'(rd_cnt), 0);
    check("t4_rst_wr_cnt", int'(wr_cnt), 0);
    check("t4_rst_rdata", int'(resp_rdata), 0);
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
    do_txn(1'b0, 5'd4, 3'd0, rd, rw, lat);
    check("t4_rdata", int'(rd), 4);

    // 5: zero-latency build, back-to-back reads
    req_valid_z = 1'b1; req_addr_z = 5'd1; resp_ready_z = 1'b1;
    @(negedge clock);
    check("t5_valid1", int'(resp_valid_z), 1);
    check("t5_rdata1", int'(resp_rdata_z), 1);
    check("t5_ready1", int'(req_ready_z), 0);
    req_addr_z = 5'd2;
    @(negedge clock);
    check("t5_gap_valid", int'(resp_valid_z), 0);
    check("t5_gap_ready", int'(req_ready_z), 1);
    @(negedge clock);
    req_valid_z = 1'b0;
    check("t5_valid2", int'(resp_valid_z), 1);
    check("t5_rdata2", int'(resp_rdata_z), 2);
    @(negedge clock);
    check("t5_rd_cnt", int'(rd_cnt_z), 2);

    // Random traffic, with occasional asynchronous reset pulses
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 1) == 1);
      req_write  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       req_addr = 5'd31;
        1:       req_addr = 5'd0;
        default: req_addr = AW'($urandom_range(0, DEPTH - 1));
      endcase
      req_wdata  = DW'($urandom_range(0, 7));
      resp_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(negedge clock);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (6) @(negedge clock);

    // 6: read counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      do_txn(1'b0, AW'($urandom_range(0, DEPTH - 1)), 3'd0, rd, rw, lat);
    end
    check("t6_rd_sat", int'(rd_cnt), 255);
    check("t6_wr_zero", int'(wr_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
